// File: rtl/frame_buffer_pkg.sv
// ---------------------------------------------------------------------------
// frame_buffer_pkg
// Shared types and constants for the single-frame buffer.
//   fb_state_t    : buffer mode, FILL (accepting writes) or DRAIN (reading out)
//   FB_*_DEF      : default frame geometry (320x240 pixels, 8-bit words)
//   FB_SKID_DEPTH : number of entries in the read-side output skid buffer
// ---------------------------------------------------------------------------
package frame_buffer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } fb_state_t;

    localparam int unsigned FB_DATA_W_DEF = 8;
    localparam int unsigned FB_DEPTH_DEF  = 76800;
    localparam int unsigned FB_ADDR_W_DEF = 17;

    localparam int unsigned FB_SKID_DEPTH = 2;

endpackage : frame_buffer_pkg

// File: rtl/frame_buffer_sdp_ram.sv
// ---------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM: one write port, one read port, single clock.
// The read port is registered (1-cycle latency); the array has no reset.
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates on the next rising edge
//   raddr_i : read address
//   rdata_o : registered read data, held while re_i is low
// ---------------------------------------------------------------------------
module sdp_ram #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 76800,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= r_mem[raddr_i];
        end
    end

endmodule : sdp_ram

// File: rtl/frame_buffer_sdp.sv
// ---------------------------------------------------------------------------
// frame_buffer_sdp
// Single-frame buffer on a simple dual-port RAM. In FILL the write side takes
// DEPTH words (valid/ready, auto-incrementing address). The buffer then
// switches to DRAIN and streams the frame out in address order through a
// 2-entry skid buffer with valid/ready backpressure, and re-arms for the next
// frame after the last word is taken.
//
// Optional build macro: FRAME_BUFFER_PARITY_EN
//   defined   : one even-parity bit stored per word, checked on read
//   undefined : parity_err_o tied low (port list unchanged)
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   wr_valid_i   : write word offered
//   wr_data_i    : write data
//   wr_ready_o   : buffer accepts a word this cycle (FILL)
//   rd_valid_o   : rd_data_o holds a valid word
//   rd_data_o    : read data, stable while stalled
//   rd_ready_i   : consumer takes the word
//   rd_last_o    : current read word is address DEPTH-1
//   frame_full_o : pulses during the cycle the word at DEPTH-1 is written
//   parity_err_o : parity mismatch on current read word (qualified by valid)
// ---------------------------------------------------------------------------
module frame_buffer_sdp
    import frame_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = FB_DATA_W_DEF,
    parameter int unsigned DEPTH  = FB_DEPTH_DEF,
    parameter int unsigned ADDR_W = FB_ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              rd_ready_i,
    output logic              rd_last_o,
    output logic              frame_full_o,
    output logic              parity_err_o
);

`ifdef FRAME_BUFFER_PARITY_EN
    localparam int unsigned RAM_W = DATA_W + 1;
`else
    localparam int unsigned RAM_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    fb_state_t         r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_wr_ready;
    logic              r_rd_done;       // all DEPTH reads of this frame issued
    logic              r_inflight;      // RAM output holds a fresh word this cycle
    logic              r_inflight_last; // ...and that word is address DEPTH-1

    // Skid buffer: head drives the outputs, tail catches the word that
    // arrives while the head is stalled. Entries carry the parity bit (if any).
    logic [1:0]        r_cnt;
    logic [RAM_W-1:0]  r_head_word;
    logic [RAM_W-1:0]  r_tail_word;
    logic              r_head_last;
    logic              r_tail_last;

    // ---------------------------------------------------------------
    // Datapath wires
    // ---------------------------------------------------------------
    logic              w_wr_xfer;
    logic              w_wr_at_last;
    logic              w_rd_valid;
    logic              w_pop;
    logic              w_last_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic [RAM_W-1:0]  w_ram_wdata;
    logic [RAM_W-1:0]  w_ram_rdata;

    assign w_wr_xfer    = wr_valid_i & r_wr_ready;
    assign w_wr_at_last = (r_wr_ptr == LAST_ADDR);
    assign w_rd_valid   = (r_cnt != 2'd0);
    assign w_pop        = w_rd_valid & rd_ready_i;
    assign w_last_pop   = w_pop & r_head_last;

    // Occupancy counts the in-flight RAM word as already buffered, so a new
    // read is only issued when there is guaranteed room for it next cycle.
    // w_pop implies r_cnt >= 1, so this cannot underflow.
    assign w_occ   = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == DRAIN) & ~r_rd_done & (w_occ < 3'(FB_SKID_DEPTH));

`ifdef FRAME_BUFFER_PARITY_EN
    assign w_ram_wdata  = {^wr_data_i, wr_data_i};
    // Even parity: XOR over data and stored bit is zero for an intact word.
    assign parity_err_o = w_rd_valid & (^r_head_word);
`else
    assign w_ram_wdata  = wr_data_i;
    assign parity_err_o = 1'b0;
`endif

    assign wr_ready_o   = r_wr_ready;
    assign rd_valid_o   = w_rd_valid;
    assign rd_data_o    = r_head_word[DATA_W-1:0];
    assign rd_last_o    = w_rd_valid & r_head_last;
    assign frame_full_o = w_wr_xfer & w_wr_at_last;

    // ---------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------
    sdp_ram #(
        .WIDTH  (RAM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (w_wr_xfer),
        .waddr_i (r_wr_ptr),
        .wdata_i (w_ram_wdata),
        .re_i    (w_issue),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_ram_rdata)
    );

    // ---------------------------------------------------------------
    // FSM, pointers and skid buffer
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= FILL;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_wr_ready      <= 1'b1;
            r_rd_done       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_cnt           <= 2'd0;
            r_head_word     <= '0;
            r_tail_word     <= '0;
            r_head_last     <= 1'b0;
            r_tail_last     <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & (r_rd_ptr == LAST_ADDR);

            case (r_state)
                FILL: begin
                    if (w_wr_xfer) begin
                        if (w_wr_at_last) begin
                            r_wr_ptr   <= '0;
                            r_wr_ready <= 1'b0;
                            r_state    <= DRAIN;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_issue) begin
                        // Pointer parks on DEPTH-1; r_rd_done blocks further reads.
                        if (r_rd_ptr == LAST_ADDR) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                    if (w_last_pop) begin
                        r_rd_ptr   <= '0;
                        r_rd_done  <= 1'b0;
                        r_wr_ready <= 1'b1;
                        r_state    <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase

            // Push comes from the RAM the cycle after a read was issued.
            case (r_cnt)
                2'd0: begin
                    if (r_inflight) begin
                        r_head_word <= w_ram_rdata;
                        r_head_last <= r_inflight_last;
                        r_cnt       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_pop) begin
                        r_head_word <= w_ram_rdata;
                        r_head_last <= r_inflight_last;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end else if (r_inflight) begin
                        r_tail_word <= w_ram_rdata;
                        r_tail_last <= r_inflight_last;
                        r_cnt       <= 2'd2;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head_word <= r_tail_word;
                        r_head_last <= r_tail_last;
                        if (r_inflight) begin
                            r_tail_word <= w_ram_rdata;
                            r_tail_last <= r_inflight_last;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
                default: begin
                    r_cnt <= 2'd0;
                end
            endcase

            if (w_last_pop) begin
                r_cnt <= 2'd0;
            end
        end
    end

endmodule : frame_buffer_sdp

// File: tb/tb_frame_buffer_sdp.sv
module tb_frame_buffer_sdp;

    localparam int unsigned DW  = 8;
    localparam int unsigned DEP = 16;
    localparam int unsigned AW  = 4;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          rd_ready = 1'b0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          frame_full;
    logic          parity_err;

    always #5 clk = ~clk;

    frame_buffer_sdp #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .ADDR_W (AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .rd_ready_i   (rd_ready),
        .rd_last_o    (rd_last),
        .frame_full_o (frame_full),
        .parity_err_o (parity_err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: compares every popped word against the scoreboard queue.
    initial begin : monitor
        exp_t          e;
        logic          prev_stall   = 1'b0;
        logic          prev_lastpop = 1'b0;
        logic [DW-1:0] prev_data    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall   = 1'b0;
                prev_lastpop = 1'b0;
            end else begin
                if (prev_lastpop) check("wr_ready_after_last_pop", 32'(wr_ready), 32'd1);
                if (prev_stall) begin
                    check("stall_valid_held", 32'(rd_valid), 32'd1);
                    check("stall_data_held", 32'(rd_data), 32'(prev_data));
                end
                if (rd_valid) check("parity_err", 32'(parity_err), 32'd0);
                else          check("rd_last_idle", 32'(rd_last), 32'd0);
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got data 0x%0h expected no word at %0t", rd_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", 32'(rd_data), 32'(e.data));
                        check("rd_last", 32'(rd_last), 32'(e.last));
                    end
                end
                prev_stall   = rd_valid && !rd_ready;
                prev_lastpop = rd_valid && rd_ready && rd_last;
                prev_data    = rd_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Writes words first..first+n-1 with data base+index; starts and ends at posedge+1.
    task automatic write_words(input int unsigned first, input int unsigned n, input logic [DW-1:0] base);
        for (int unsigned i = first; i < first + n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            @(negedge clk);
            check("wr_ready_fill", 32'(wr_ready), 32'd1);
            check("frame_full", 32'(frame_full), 32'(i == DEP - 1));
            exp_q.push_back('{data: wr_data, last: (i == DEP - 1)});
            tick();
        end
        wr_valid = 1'b0;
    endtask

    // Drives rd_ready until the scoreboard empties; cycles = negedges observed.
    task automatic drain(input bit random_ready, input bit hold_chk,
                         input int unsigned budget, output int unsigned cycles);
        cycles = 0;
        while (1) begin
            rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            #2;
            cycles++;
            if (hold_chk) check("wr_ready_drain", 32'(wr_ready), 32'd0);
            if (exp_q.size() == 0) break;
            if (cycles >= budget) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
                break;
            end
            tick();
        end
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin : stim
        int unsigned cyc;

        // Reset values
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_frame_full", 32'(frame_full), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        tick();

        // Frame 1: data = addr; latency then full-rate drain from a full skid
        write_words(0, DEP, 8'h00);
        @(negedge clk);
        check("wr_ready_after_full", 32'(wr_ready), 32'd0);
        check("frame_full_once", 32'(frame_full), 32'd0);
        check("rd_valid_lat1", 32'(rd_valid), 32'd0);
        tick();
        @(negedge clk);
        check("rd_valid_lat2", 32'(rd_valid), 32'd0);
        tick();
        @(negedge clk);
        check("rd_valid_lat3", 32'(rd_valid), 32'd1);
        check("first_word", 32'(rd_data), 32'd0);
        tick();
        tick();
        drain(1'b0, 1'b1, 64, cyc);
        check("full_rate_cycles", 32'(cyc), 32'(DEP));

        // Frame 2: random backpressure while producer holds 0xAA
        write_words(0, DEP, 8'h00);
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        drain(1'b1, 1'b1, 400, cyc);
        // Held word becomes word 0 of frame 3 once FILL is re-entered.
        @(negedge clk);
        check("hold_accept_ready", 32'(wr_ready), 32'd1);
        exp_q.push_back('{data: 8'hAA, last: 1'b0});
        tick();
        write_words(1, DEP - 1, 8'h30);
        drain(1'b0, 1'b0, 64, cyc);

        // Reset mid-fill discards the partial frame
        do_reset();
        write_words(0, 7, 8'h40);
        do_reset();
        write_words(0, DEP, 8'h80);
        drain(1'b0, 1'b0, 64, cyc);

        // Reset mid-drain
        write_words(0, DEP, 8'h10);
        rd_ready = 1'b1;
        repeat (6) tick();
        rst      = 1'b1;
        rd_ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_drain_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_drain_rst_ready", 32'(wr_ready), 32'd1);
        tick();
        write_words(0, DEP, 8'h50);
        drain(1'b1, 1'b0, 400, cyc);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_frame_buffer_sdp
